duck_stream_tx: RTL and testbench

Transmit end of the Duck Stream (L4) link. Accepts one 256-bit hash per transaction and serialises it onto a 32-bit beat stream as a framed packet: sync word, eight data beats, checksum beat. Runs the same Berry Phase accumulator as the receiver so that frames start only inside the phase window the receiver reports as sync lock. It sits between the hash core and the L4 physical stream.

---
 rtl/duck_stream_pkg.sv | 27 ++
 rtl/duck_phase_acc.sv | 23 ++
 rtl/duck_stream_tx.sv | 136 +++++++++++++
 tb/tb_duck_stream_tx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/duck_stream_pkg.sv
// Shared constants and types for the Duck Stream (L4) link, used by both the
// transmitter and the receiver-side checker.
package duck_stream_pkg;

  localparam int unsigned BEAT_W     = 32;
  localparam int unsigned HASH_W     = 256;
  localparam int unsigned NUM_BEATS  = HASH_W / BEAT_W;
  localparam int unsigned BEAT_IDX_W = $clog2(NUM_BEATS);

  localparam logic [15:0]       PHASE_STEP  = 16'h0578;
  localparam logic [15:0]       LOCK_THRESH = 16'hF000;
  localparam logic [BEAT_W-1:0] SYNC_WORD   = 32'hD0C5_7A3E;

  typedef enum logic [2:0] {
    StIdle,
    StWaitWin,
    StSync,
    StData,
    StCsum
  } tx_state_e;

  // Most significant beat of a payload; data goes out MSB word first.
  function automatic logic [BEAT_W-1:0] top_word(input logic [HASH_W-1:0] h);
    return h[HASH_W-1 -: BEAT_W];
  endfunction

endpackage

// File: rtl/duck_phase_acc.sv
// Berry Phase accumulator and sync-lock window compare. Free-running so both
// link ends derive identical window timing from reset.
module duck_phase_acc
  import duck_stream_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  output logic phase_lock
);

  logic [15:0] phase_acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_acc_q <= 16'h0000;
    end else begin
      phase_acc_q <= phase_acc_q + PHASE_STEP;
    end
  end

  assign phase_lock = (phase_acc_q > LOCK_THRESH);

endmodule

// File: rtl/duck_stream_tx.sv
// Duck Stream transmitter: latches one hash and sends it as a framed packet
// (sync word, eight data beats, XOR checksum) launched only inside the phase window.
module duck_stream_tx
  import duck_stream_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [HASH_W-1:0] hash_in,
  input  logic              hash_valid,
  output logic              hash_ready,
  output logic [BEAT_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_sof,
  output logic              tx_eof,
  output logic              phase_lock,
  output logic [15:0]       frames_sent
);

  tx_state_e             state_q, state_d;
  logic [BEAT_IDX_W-1:0] beat_q, beat_d;
  logic [HASH_W-1:0]     shift_q, shift_d;
  logic [BEAT_W-1:0]     csum_q, csum_d;
  logic [BEAT_W-1:0]     tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_sof_q, tx_sof_d;
  logic                  tx_eof_q, tx_eof_d;
  logic [15:0]           frames_q, frames_d;
  logic                  accept;

  duck_phase_acc u_phase_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .phase_lock (phase_lock)
  );

  assign hash_ready = rst_n && (state_q == StIdle);
  assign accept     = hash_valid && hash_ready;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    shift_d    = shift_q;
    csum_d     = csum_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_sof_d   = tx_sof_q;
    tx_eof_d   = tx_eof_q;
    frames_d   = frames_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d = hash_in;
          state_d = StWaitWin;
        end
      end
      StWaitWin: begin
        if (phase_lock) begin
          state_d    = StSync;
          tx_data_d  = SYNC_WORD;
          tx_valid_d = 1'b1;
          tx_sof_d   = 1'b1;
        end
      end
      StSync: begin
        if (tx_ready) begin
          state_d   = StData;
          beat_d    = '0;
          tx_data_d = top_word(shift_q);
          tx_sof_d  = 1'b0;
          // Checksum restarts with the first word each frame.
          csum_d    = top_word(shift_q);
          shift_d   = shift_q << BEAT_W;
        end
      end
      StData: begin
        if (tx_ready) begin
          if (beat_q == BEAT_IDX_W'(NUM_BEATS - 1)) begin
            state_d   = StCsum;
            tx_data_d = csum_q;
            tx_eof_d  = 1'b1;
          end else begin
            beat_d    = beat_q + BEAT_IDX_W'(1);
            tx_data_d = top_word(shift_q);
            csum_d    = csum_q ^ top_word(shift_q);
            shift_d   = shift_q << BEAT_W;
          end
        end
      end
      StCsum: begin
        if (tx_ready) begin
          state_d    = StIdle;
          tx_data_d  = '0;
          tx_valid_d = 1'b0;
          tx_eof_d   = 1'b0;
          frames_d   = frames_q + 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      shift_q    <= '0;
      csum_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_sof_q   <= 1'b0;
      tx_eof_q   <= 1'b0;
      frames_q   <= 16'h0000;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      shift_q    <= shift_d;
      csum_q     <= csum_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_sof_q   <= tx_sof_d;
      tx_eof_q   <= tx_eof_d;
      frames_q   <= frames_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign tx_sof      = tx_sof_q;
  assign tx_eof      = tx_eof_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_duck_stream_tx.sv
// Directed bench for duck_stream_tx: window timing, framing, checksum,
// backpressure, back-to-back frames and mid-frame reset.
module tb_duck_stream_tx;

  logic         clk;
  logic         rst_n;
  logic [255:0] hash_in;
  logic         hash_valid;
  logic         hash_ready;
  logic [31:0]  tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx_sof;
  logic         tx_eof;
  logic         phase_lock;
  logic [15:0]  frames_sent;

  int          total;
  int          bad;
  int          edge_n;
  logic [31:0] last_csum;

  localparam logic [31:0] SYNC = 32'hD0C5_7A3E;

  localparam logic [255:0] H1 = {32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004,
                                 32'h0000_0005, 32'h0000_0006, 32'h0000_0007, 32'h0000_0008};
  localparam logic [255:0] H2 = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hCAFE_F00D,
                                 32'h0F0F_0F0F, 32'h1234_5678, 32'hA5A5_A5A5, 32'hFFFF_0000};
  localparam logic [255:0] H3 = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                                 32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888};
  localparam logic [255:0] H4 = {32'h8000_0000, 32'h4000_0000, 32'h2000_0000, 32'h1000_0000,
                                 32'h0800_0000, 32'h0400_0000, 32'h0200_0000, 32'h0100_0000};

  duck_stream_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hash_in     (hash_in),
    .hash_valid  (hash_valid),
    .hash_ready  (hash_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_sof      (tx_sof),
    .tx_eof      (tx_eof),
    .phase_lock  (phase_lock),
    .frames_sent (frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Waits (bounded) for a launch, then walks the 10-beat frame checking every
  // presented beat; stalled cycles re-check the held beat.
  task automatic frame_run(input logic [255:0] h, input int stall_at, input bit toggle,
                           input int launch_edge, input logic [15:0] exp_frames);
    logic [31:0] exp_w [10];
    logic [31:0] acc;
    logic [31:0] w;
    int          k;
    int          guard;
    int          stall_cnt;
    bit          tog;
    bit          rdy;
    acc = '0;
    exp_w[0] = SYNC;
    for (int i = 0; i < 8; i++) begin
      w = h[255 - 32*i -: 32];
      exp_w[i+1] = w;
      acc = acc ^ w;
    end
    exp_w[9] = acc;

    guard = 0;
    while (!tx_valid && guard < 200) begin
      step();
      guard++;
    end
    if (!tx_valid) chk("launch_timeout", 32'(tx_valid), 32'd1);
    if (launch_edge >= 0) chk("launch_edge", edge_n, launch_edge);

    k = 0;
    stall_cnt = 0;
    tog = 1'b1;
    guard = 0;
    while (k < 10 && guard < 100) begin
      if (k == stall_at && stall_cnt < 5) begin
        rdy = 1'b0;
        stall_cnt++;
      end else if (toggle) begin
        rdy = tog;
        tog = ~tog;
      end else begin
        rdy = 1'b1;
      end
      tx_ready = rdy;
      chk("beat_data", tx_data, exp_w[k]);
      chk("beat_valid", 32'(tx_valid), 32'd1);
      chk("beat_sof", 32'(tx_sof), 32'(k == 0));
      chk("beat_eof", 32'(tx_eof), 32'(k == 9));
      chk("busy_ready", 32'(hash_ready), 32'd0);
      if (k == 9) last_csum = tx_data;
      step();
      if (rdy) k++;
      guard++;
    end
    if (k < 10) chk("frame_timeout", k, 32'd10);
    tx_ready = 1'b1;
    chk("post_valid", 32'(tx_valid), 32'd0);
    chk("post_eof", 32'(tx_eof), 32'd0);
    chk("post_ready", 32'(hash_ready), 32'd1);
    chk("frames_sent", {16'h0, frames_sent}, {16'h0, exp_frames});
  endtask

  initial begin
    int guard;
    total      = 0;
    bad        = 0;
    edge_n     = 0;
    last_csum  = '0;
    rst_n      = 1'b0;
    hash_valid = 1'b0;
    hash_in    = '0;
    tx_ready   = 1'b1;

    #12;
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_sof", 32'(tx_sof), 32'd0);
    chk("rst_eof", 32'(tx_eof), 32'd0);
    chk("rst_data", tx_data, 32'd0);
    chk("rst_frames", {16'h0, frames_sent}, 32'd0);
    chk("rst_phase", {16'h0, dut.u_phase_acc.phase_acc_q}, 32'd0);

    // Frame 1: accept on edge 1, launch at edge 45, payload words 1..8.
    @(negedge clk);
    rst_n      = 1'b1;
    hash_valid = 1'b1;
    hash_in    = H1;
    edge_n     = 0;
    #1;
    chk("idle_ready", 32'(hash_ready), 32'd1);
    step();
    chk("accepted", 32'(hash_ready), 32'd0);
    hash_valid = 1'b0;
    hash_in    = ~H1;
    repeat (42) step();
    chk("lock_e43", 32'(phase_lock), 32'd0);
    step();
    chk("lock_e44", 32'(phase_lock), 32'd1);
    chk("phase_e44", {16'h0, dut.u_phase_acc.phase_acc_q}, 32'h0000_F0A0);
    chk("novalid_e44", 32'(tx_valid), 32'd0);
    frame_run(H1, -1, 1'b0, 45, 16'd1);
    chk("frame1_end", edge_n, 32'd55);
    chk("csum_1to8", last_csum, 32'h0000_0008);

    // Frame 2: hash_valid held high, stall on data beat 3, then ready toggling.
    hash_valid = 1'b1;
    hash_in    = H2;
    step();
    hash_in = H3;
    frame_run(H2, 4, 1'b1, 92, 16'd2);

    // Frame 3 (H3, accepted right after frame 2): reset during data beat 4.
    guard = 0;
    while (!tx_valid && guard < 200) begin
      step();
      guard++;
    end
    chk("f3_launch", 32'(tx_valid), 32'd1);
    tx_ready = 1'b1;
    repeat (5) step();
    chk("f3_beat4", tx_data, 32'h5555_5555);
    hash_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_eof", 32'(tx_eof), 32'd0);
    chk("mid_rst_data", tx_data, 32'd0);
    chk("mid_rst_frames", {16'h0, frames_sent}, 32'd0);
    chk("mid_rst_phase", {16'h0, dut.u_phase_acc.phase_acc_q}, 32'd0);

    // Window miss: accept at edge 47 after phase wraps, launch at edge 92.
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
    #1;
    chk("rel_ready", 32'(hash_ready), 32'd1);
    repeat (46) step();
    chk("lock_e46", 32'(phase_lock), 32'd1);
    chk("idle_e46", 32'(tx_valid), 32'd0);
    hash_valid = 1'b1;
    hash_in    = H4;
    step();
    chk("miss_accept", 32'(hash_ready), 32'd0);
    chk("lock_e47", 32'(phase_lock), 32'd0);
    hash_valid = 1'b0;
    repeat (43) step();
    chk("wait_e90", 32'(tx_valid), 32'd0);
    step();
    chk("lock_e91", 32'(phase_lock), 32'd1);
    chk("wait_e91", 32'(tx_valid), 32'd0);
    frame_run(H4, -1, 1'b0, 92, 16'd1);
    chk("csum_h4", last_csum, 32'hFF00_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
